alu_cmd_sequencer: RTL and testbench

- Initiator side of the 40-bit registered ALU interface (opcode `s`, operands `a`/`b`, result `out`).
- Buffers a batch of up to DEPTH commands written by a host. On `start`, it issues them to the ALU one at a time, waits the ALU latency, and captures each result into a result buffer the host reads back by index.
- Sits between the host/test controller and the ALU instance.

---
 rtl/alu_cmd_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Batch command sequencer for the registered ALU: buffers up to DEPTH commands, issues them one at a time,
// captures each result ALU_LAT+1 edges after issue; illegal opcodes are skipped in one cycle, writes ignored while busy.
module alu_cmd_sequencer #(
   parameter int DW      = 40,
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int ALU_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_wr_en,
   input  logic [4:0]    cmd_wr_s,
   input  logic [DW-1:0] cmd_wr_a,
   input  logic [DW-1:0] cmd_wr_b,
   output logic          cmd_full,
   output logic [AW:0]   cmd_count,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          err_illegal,
   output logic [4:0]    alu_s,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_out,
   input  logic [AW-1:0] res_rd_addr,
   output logic [DW-1:0] res_rd_data,
   output logic [AW:0]   res_count
);

   localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] LAT_LOAD = CW'(ALU_LAT);
   localparam logic [CW-1:0] LAT_ONE  = CW'(1);

   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00101;
   localparam logic [4:0] OP_ADDM = 5'b00111;
   localparam logic [4:0] OP_SUB  = 5'b00110;
   localparam logic [4:0] OP_AND  = 5'b01000;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_SHA  = 5'b01100;
   localparam logic [4:0] OP_SHB  = 5'b10100;

   typedef struct packed {
      logic [4:0]    s;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   cmd_t          cmd_mem [DEPTH];
   logic [DW-1:0] res_mem [DEPTH];

   state_t        state;
   logic [AW:0]   idx;
   logic [CW-1:0] wait_cnt;

   cmd_t          cur_cmd;
   cmd_t          wr_cmd;
   logic          cur_legal;
   logic [AW:0]   idx_next;
   logic          last_cmd;
   logic          cmd_we;
   logic          res_we;

   function automatic logic op_legal(input logic [4:0] op);
      case (op)
         OP_ADD, OP_ADDM, OP_SUB, OP_AND, OP_OR, OP_SHA, OP_SHB: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      cur_cmd   = cmd_mem[idx[AW-1:0]];
      cur_legal = op_legal(cur_cmd.s);
      idx_next  = idx + CNT_ONE;
      last_cmd  = (idx_next == cmd_count);
      wr_cmd.s  = cmd_wr_s;
      wr_cmd.a  = cmd_wr_a;
      wr_cmd.b  = cmd_wr_b;
      // start takes priority over a same-cycle write
      cmd_we    = !rst && (state == ST_IDLE) && cmd_wr_en && !start && !cmd_full;
      res_we    = !rst && (state == ST_CAPTURE);
   end

   assign cmd_full    = (cmd_count == CNT_FULL);
   assign res_rd_data = res_mem[res_rd_addr];

   always_ff @(posedge clk) begin
      if (cmd_we) begin
         cmd_mem[cmd_count[AW-1:0]] <= wr_cmd;
      end
   end

   always_ff @(posedge clk) begin
      if (res_we) begin
         res_mem[res_count[AW-1:0]] <= alu_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
         cmd_count   <= '0;
         res_count   <= '0;
         idx         <= '0;
         wait_cnt    <= '0;
         alu_s       <= OP_NOP;
         alu_a       <= '0;
         alu_b       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (cmd_count == '0) begin
                     done <= 1'b1;
                  end else begin
                     res_count   <= '0;
                     err_illegal <= 1'b0;
                     idx         <= '0;
                     busy        <= 1'b1;
                     state       <= ST_ISSUE;
                  end
               end else if (cmd_wr_en && !cmd_full) begin
                  cmd_count <= cmd_count + CNT_ONE;
               end
            end

            ST_ISSUE: begin
               if (cur_legal) begin
                  alu_s    <= cur_cmd.s;
                  alu_a    <= cur_cmd.a;
                  alu_b    <= cur_cmd.b;
                  wait_cnt <= LAT_LOAD;
                  state    <= ST_WAIT;
               end else begin
                  // illegal opcodes never reach the ALU
                  err_illegal <= 1'b1;
                  idx         <= idx_next;
                  if (last_cmd) begin
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     cmd_count <= '0;
                     state     <= ST_DONE;
                  end
               end
            end

            ST_WAIT: begin
               if (wait_cnt <= LAT_ONE) begin
                  state <= ST_CAPTURE;
               end
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - LAT_ONE;
               end
            end

            ST_CAPTURE: begin
               res_count <= res_count + CNT_ONE;
               alu_s     <= OP_NOP;
               idx       <= idx_next;
               if (last_cmd) begin
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  cmd_count <= '0;
                  state     <= ST_DONE;
               end else begin
                  state <= ST_ISSUE;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU stub and a batch-level reference model.
module tb_alu_cmd_sequencer;

   localparam int DW      = 40;
   localparam int DEPTH   = 8;
   localparam int AW      = 3;
   localparam int ALU_LAT = 1;

   typedef struct packed {
      logic [4:0]    s;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } op_t;

   typedef struct packed {
      logic [15:0]                busy;
      logic [AW:0]                rcnt;
      logic                       err;
      logic [DEPTH-1:0][DW-1:0]   res;
   } rec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_wr_en;
   logic [4:0]    cmd_wr_s;
   logic [DW-1:0] cmd_wr_a;
   logic [DW-1:0] cmd_wr_b;
   logic          cmd_full;
   logic [AW:0]   cmd_count;
   logic          start;
   logic          busy;
   logic          done;
   logic          err_illegal;
   logic [4:0]    alu_s;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_out = '0;
   logic [AW-1:0] res_rd_addr = '0;
   logic [DW-1:0] res_rd_data;
   logic [AW:0]   res_count;

   int n_tests = 0;
   int n_fail  = 0;

   op_t           m_cmds [$];
   op_t           iss_q  [$];
   rec_t          rec_q  [$];
   logic [DW-1:0] m_res  [$];
   logic          m_err = 1'b0;

   always #20 clk = ~clk;

   alu_cmd_sequencer #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .ALU_LAT(ALU_LAT)) dut (
      .clk(clk), .rst(rst),
      .cmd_wr_en(cmd_wr_en), .cmd_wr_s(cmd_wr_s), .cmd_wr_a(cmd_wr_a), .cmd_wr_b(cmd_wr_b),
      .cmd_full(cmd_full), .cmd_count(cmd_count),
      .start(start), .busy(busy), .done(done), .err_illegal(err_illegal),
      .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
      .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data), .res_count(res_count)
   );

   function automatic logic [DW-1:0] alu_fn(input logic [4:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] ma, mb;
      ma = a[DW-1] ? (~a + 1'b1) : a;
      mb = b[DW-1] ? (~b + 1'b1) : b;
      case (s)
         5'b00101: return a + b;
         5'b00111: return ma + mb;
         5'b00110: return a - b;
         5'b01000: return DW'((a != '0) && (b != '0));
         5'b01011: return DW'((a != '0) || (b != '0));
         5'b01100: return a >> 2;
         5'b10100: return a << 2;
         default:  return '0;
      endcase
   endfunction

   // Registered ALU: one edge from input sample to valid out, holds on the idle opcode.
   always @(posedge clk) begin
      if (alu_s != 5'b00000) alu_out <= alu_fn(alu_s, alu_a, alu_b);
   end

   function automatic bit is_legal(input logic [4:0] s);
      return s inside {5'b00101, 5'b00111, 5'b00110, 5'b01000, 5'b01011, 5'b01100, 5'b10100};
   endfunction

   function automatic logic [4:0] rand_legal();
      logic [4:0] ops [7];
      ops = '{5'b00101, 5'b00111, 5'b00110, 5'b01000, 5'b01011, 5'b01100, 5'b10100};
      return ops[$urandom_range(0, 6)];
   endfunction

   function automatic logic [DW-1:0] rnd_dw();
      logic [63:0] t;
      t = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) t = '0;
      return t[DW-1:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr_cmd(input logic [4:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
      op_t o;
      cmd_wr_en = 1'b1;
      cmd_wr_s  = s;
      cmd_wr_a  = a;
      cmd_wr_b  = b;
      @(posedge clk); #1;
      cmd_wr_en = 1'b0;
      o.s = s; o.a = a; o.b = b;
      if (m_cmds.size() < DEPTH) m_cmds.push_back(o);
   endtask

   // Reference model: a batch's expected results, error flag and busy length from the command list.
   task automatic start_batch(input bit use_lit, input logic [DEPTH-1:0][DW-1:0] lit,
                              input bit expect_done, input bit with_wr);
      rec_t r;
      r = '0;
      if (m_cmds.size() != 0) begin
         m_res.delete();
         m_err = 1'b0;
         foreach (m_cmds[i]) begin
            if (is_legal(m_cmds[i].s)) begin
               m_res.push_back(alu_fn(m_cmds[i].s, m_cmds[i].a, m_cmds[i].b));
               iss_q.push_back(m_cmds[i]);
               r.busy = r.busy + 16'(ALU_LAT + 2);
            end else begin
               m_err  = 1'b1;
               r.busy = r.busy + 16'd1;
            end
         end
         m_cmds.delete();
      end
      r.rcnt = (AW+1)'(m_res.size());
      r.err  = m_err;
      foreach (m_res[i]) r.res[i] = m_res[i];
      if (use_lit) r.res = lit;
      if (expect_done) rec_q.push_back(r);
      start = 1'b1;
      if (with_wr) begin
         cmd_wr_en = 1'b1;
         cmd_wr_s  = 5'b00101;
         cmd_wr_a  = rnd_dw();
         cmd_wr_b  = rnd_dw();
      end
      @(posedge clk); #1;
      start     = 1'b0;
      cmd_wr_en = 1'b0;
   endtask

   task automatic wait_done(input string name, output int cyc);
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            cyc  = c;
            break;
         end
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: no done within 200 cycles", name);
      end
      @(posedge clk); #1;
   endtask

   // Monitor: ALU issue order and hold time, batch completion and read-back of results.
   initial begin
      logic [4:0] prev_s;
      logic       prev_done;
      int         busy_cnt;
      int         hold;
      bit         aborted;
      op_t        cur;
      rec_t       r;
      prev_s = '0; prev_done = 1'b0; busy_cnt = 0; hold = 0; aborted = 1'b0; cur = '0;
      forever begin
         @(negedge clk);
         if (rst) busy_cnt = 0;
         else if (busy) busy_cnt++;

         if (alu_s != 5'b00000 && prev_s == 5'b00000) begin
            aborted = rst;
            hold    = 1;
            if (iss_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_issue: alu_s=0x%0h with nothing pending", alu_s);
               cur.s = alu_s; cur.a = alu_a; cur.b = alu_b;
            end else begin
               cur = iss_q.pop_front();
               chk("issue_s", 64'(alu_s), 64'(cur.s));
               chk("issue_a", 64'(alu_a), 64'(cur.a));
               chk("issue_b", 64'(alu_b), 64'(cur.b));
            end
         end else if (alu_s != 5'b00000) begin
            hold++;
            chk("hold_s", 64'(alu_s), 64'(cur.s));
            chk("hold_a", 64'(alu_a), 64'(cur.a));
            chk("hold_b", 64'(alu_b), 64'(cur.b));
         end else if (prev_s != 5'b00000) begin
            if (!aborted && !rst) chk("hold_len", 64'(hold), 64'(ALU_LAT + 1));
            hold = 0;
         end
         if (rst) aborted = 1'b1;

         if (done && !rst) begin
            chk("done_width", 64'(prev_done), 64'd0);
            chk("busy_at_done", 64'(busy), 64'd0);
            if (rec_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: done=1 with no batch pending");
            end else begin
               r = rec_q.pop_front();
               chk("busy_cycles", 64'(busy_cnt), 64'(r.busy));
               chk("res_count", 64'(res_count), 64'(r.rcnt));
               chk("err_illegal", 64'(err_illegal), 64'(r.err));
               prev_s    = alu_s;
               prev_done = done;
               for (int i = 0; i < int'(r.rcnt); i++) begin
                  res_rd_addr = AW'(i);
                  #1;
                  chk($sformatf("result[%0d]", i), 64'(res_rd_data), 64'(r.res[i]));
               end
            end
            busy_cnt = 0;
         end
         prev_s    = alu_s;
         prev_done = done;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DEPTH-1:0][DW-1:0] lit;
      int cyc;
      rst = 1'b1; cmd_wr_en = 1'b0; cmd_wr_s = '0; cmd_wr_a = '0; cmd_wr_b = '0; start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err_illegal), 64'd0);
      chk("rst_full", 64'(cmd_full), 64'd0);
      chk("rst_cmd_count", 64'(cmd_count), 64'd0);
      chk("rst_res_count", 64'(res_count), 64'd0);
      chk("rst_alu_s", 64'(alu_s), 64'd0);
      chk("rst_alu_a", 64'(alu_a), 64'd0);
      chk("rst_alu_b", 64'(alu_b), 64'd0);
      @(posedge clk); #1;

      // single add
      wr_cmd(5'b00101, 40'h0B, 40'h03);
      lit = '0; lit[0] = 40'h0E;
      start_batch(1'b1, lit, 1'b1, 1'b0);
      wait_done("t1", cyc);
      chk("t1_cmd_count_clr", 64'(cmd_count), 64'd0);

      // one of each operation
      wr_cmd(5'b00101, 40'h0B, 40'h03);
      wr_cmd(5'b00111, 40'h0B, 40'h03);
      wr_cmd(5'b00110, 40'h0B, 40'h03);
      wr_cmd(5'b01000, 40'h0B, 40'h03);
      wr_cmd(5'b01011, 40'h0B, 40'h03);
      wr_cmd(5'b01100, 40'h0B, 40'h03);
      chk("t2_cmd_count", 64'(cmd_count), 64'd6);
      lit = '0;
      lit[0] = 40'h0E; lit[1] = 40'h0E; lit[2] = 40'h08;
      lit[3] = 40'h01; lit[4] = 40'h01; lit[5] = 40'h02;
      start_batch(1'b1, lit, 1'b1, 1'b0);
      wait_done("t2", cyc);

      // overfill
      for (int i = 0; i < 9; i++) begin
         wr_cmd(rand_legal(), rnd_dw(), rnd_dw());
         if (i == 6) chk("t3_full_at_7", 64'(cmd_full), 64'd0);
         if (i == 7) chk("t3_full_at_8", 64'(cmd_full), 64'd1);
      end
      chk("t3_cmd_count", 64'(cmd_count), 64'(DEPTH));
      chk("t3_full_after_9", 64'(cmd_full), 64'd1);
      start_batch(1'b0, '0, 1'b1, 1'b0);
      wait_done("t3", cyc);

      // illegal opcode in the middle
      wr_cmd(5'b00101, 40'h0B, 40'h03);
      wr_cmd(5'b11111, 40'h0B, 40'h03);
      wr_cmd(5'b00110, 40'h0B, 40'h03);
      lit = '0; lit[0] = 40'h0E; lit[1] = 40'h08;
      start_batch(1'b1, lit, 1'b1, 1'b0);
      wait_done("t4", cyc);

      // empty start together with a write
      start_batch(1'b0, '0, 1'b1, 1'b1);
      chk("t5_alu_s", 64'(alu_s), 64'd0);
      wait_done("t5", cyc);
      chk("t5_done_latency", 64'(cyc), 64'd1);
      chk("t5_write_dropped", 64'(cmd_count), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);

      // randomized batches
      for (int b = 0; b < 25; b++) begin
         int n;
         n = $urandom_range(0, DEPTH + 2);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) wr_cmd(5'($urandom_range(0, 31)), rnd_dw(), rnd_dw());
            else wr_cmd(rand_legal(), rnd_dw(), rnd_dw());
         end
         chk("rnd_cmd_count", 64'(cmd_count), 64'((n > DEPTH) ? DEPTH : n));
         start_batch(1'b0, '0, 1'b1, 1'($urandom_range(0, 1)));
         wait_done("rnd", cyc);
      end

      // reset while the second command waits on the ALU
      wr_cmd(5'b00101, 40'h0B, 40'h03);
      wr_cmd(5'b00110, 40'h0B, 40'h03);
      wr_cmd(5'b01011, 40'h0B, 40'h03);
      start_batch(1'b0, '0, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      iss_q.delete();
      m_cmds.delete();
      m_res.delete();
      m_err = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_cmd_count", 64'(cmd_count), 64'd0);
      chk("mid_rst_res_count", 64'(res_count), 64'd0);
      chk("mid_rst_alu_s", 64'(alu_s), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_err", 64'(err_illegal), 64'd0);
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1;

      // recovery batch
      wr_cmd(5'b10100, rnd_dw(), rnd_dw());
      wr_cmd(5'b00111, rnd_dw(), rnd_dw());
      start_batch(1'b0, '0, 1'b1, 1'b0);
      wait_done("recover", cyc);

      repeat (3) @(posedge clk);
      chk("pending_batches", 64'(rec_q.size()), 64'd0);
      chk("pending_issues", 64'(iss_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
